// File: rtl/mem_burst_controller.sv
// ---------------------------------------------------------------------------
// mem_burst_controller
//
// Byte-serial command interpreter sitting between a UART-style RX/TX FIFO
// pair and a single-port word memory.  Packets arrive as a command byte,
// AB address bytes (MSB first) and then, depending on the command, a
// length byte and/or data bytes.  Supported commands:
//   0x30 single read   : echo one word on TX
//   0x31 single write  : NB data bytes, one memory word
//   0x32 burst read    : LEN byte, echo LEN+1 words
//   0x33 burst write   : LEN byte, LEN+1 words of data
// Any other command byte is dropped and latches the sticky error flag.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   rx_fifo_empty in   RX FIFO holds no byte
//   rx_fifo_rd_en out  RX pop, din valid the following cycle
//   din           in   RX byte
//   tx_fifo_full  in   TX FIFO cannot accept a byte
//   tx_fifo_wr_en out  TX push, dout sampled in the same cycle
//   dout          out  TX byte
//   mem_en        out  memory access enable
//   mem_we        out  per-byte memory write enable
//   mem_addr      out  memory word address
//   mem_din       out  memory write data
//   mem_dout      in   memory read data, one cycle after a read access
//   state_leds    out  [3:0] state code, [4] burst active, [5] sticky error
// ---------------------------------------------------------------------------
module mem_burst_controller #(
    parameter int FIFO_WIDTH = 8,
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 256,
    localparam int NB        = MEM_WIDTH / 8,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_fifo_empty,
    output logic                  rx_fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  tx_fifo_full,
    output logic                  tx_fifo_wr_en,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  mem_en,
    output logic [NB-1:0]         mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [MEM_WIDTH-1:0]  mem_din,
    input  logic [MEM_WIDTH-1:0]  mem_dout,
    output logic [5:0]            state_leds
);

    localparam int AB = (AW + 7) / 8;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_READ_CMD  = 4'd1;
    localparam logic [3:0] S_READ_ADDR = 4'd2;
    localparam logic [3:0] S_READ_LEN  = 4'd3;
    localparam logic [3:0] S_READ_DATA = 4'd4;
    localparam logic [3:0] S_WRITE_MEM = 4'd5;
    localparam logic [3:0] S_READ_MEM  = 4'd6;
    localparam logic [3:0] S_ECHO      = 4'd7;
    localparam logic [3:0] S_DISCARD   = 4'd8;

    logic [3:0]           r_state;
    logic                 r_rdPend;
    logic [1:0]           r_byteCnt;
    logic                 r_cmdBurst;
    logic                 r_cmdWrite;
    logic [AW-1:0]        r_addr;
    logic [8:0]           r_count;
    logic [MEM_WIDTH-1:0] r_data;
    logic                 r_memPhase;
    logic                 r_burst;
    logic                 r_err;

    logic                 w_collect;
    logic                 w_rdEn;
    logic                 w_cmdLegal;
    logic                 w_lastWord;
    logic [3:0]           w_nextWordState;
    logic [AW-1:0]        w_addrNext;
    logic [MEM_WIDTH-1:0] w_dataNext;

    // Byte fetch handshake: a pop is issued only when no fetch is in flight,
    // and the popped byte is consumed in the cycle after (r_rdPend high).
    assign w_collect = (r_state == S_READ_CMD)  || (r_state == S_READ_ADDR) ||
                       (r_state == S_READ_LEN)  || (r_state == S_READ_DATA);
    assign w_rdEn    = w_collect && !r_rdPend && !rx_fifo_empty;

    assign w_cmdLegal = (din >= 8'h30) && (din <= 8'h33);

    // Shifting through the truncating cast keeps only the low AW bits, which
    // is exactly the "ignore address bits beyond AW" behaviour.
    assign w_addrNext = AW'({r_addr, din});
    assign w_dataNext = MEM_WIDTH'({r_data, din});

    assign w_lastWord      = (r_count == 9'd1);
    assign w_nextWordState = w_lastWord ? S_IDLE :
                             (r_cmdWrite ? S_READ_DATA : S_READ_MEM);

    // Main sequencer: parses the packet, runs the memory accesses and
    // steps address/count after every completed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rdPend   <= 1'b0;
            r_byteCnt  <= '0;
            r_cmdBurst <= 1'b0;
            r_cmdWrite <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_data     <= '0;
            r_memPhase <= 1'b0;
            r_burst    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_rdEn) begin
                r_rdPend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!rx_fifo_empty) begin
                        r_state <= S_READ_CMD;
                    end
                end
                S_READ_CMD: begin
                    if (r_rdPend) begin
                        r_rdPend   <= 1'b0;
                        r_byteCnt  <= '0;
                        r_cmdBurst <= din[1];
                        r_cmdWrite <= din[0];
                        if (w_cmdLegal) begin
                            r_state <= S_READ_ADDR;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_DISCARD;
                        end
                    end
                end
                S_READ_ADDR: begin
                    if (r_rdPend) begin
                        r_rdPend <= 1'b0;
                        r_addr   <= w_addrNext;
                        if (r_byteCnt == 2'(AB - 1)) begin
                            r_byteCnt <= '0;
                            r_count   <= 9'd1;
                            if (r_cmdBurst) begin
                                r_state <= S_READ_LEN;
                            end else if (r_cmdWrite) begin
                                r_state <= S_READ_DATA;
                            end else begin
                                r_state <= S_READ_MEM;
                            end
                        end else begin
                            r_byteCnt <= r_byteCnt + 2'd1;
                        end
                    end
                end
                S_READ_LEN: begin
                    if (r_rdPend) begin
                        r_rdPend <= 1'b0;
                        r_count  <= 9'(din) + 9'd1;
                        r_burst  <= 1'b1;
                        r_state  <= r_cmdWrite ? S_READ_DATA : S_READ_MEM;
                    end
                end
                S_READ_DATA: begin
                    if (r_rdPend) begin
                        r_rdPend <= 1'b0;
                        r_data   <= w_dataNext;
                        if (r_byteCnt == 2'(NB - 1)) begin
                            r_byteCnt <= '0;
                            r_state   <= S_WRITE_MEM;
                        end else begin
                            r_byteCnt <= r_byteCnt + 2'd1;
                        end
                    end
                end
                S_WRITE_MEM: begin
                    r_count <= r_count - 9'd1;
                    r_addr  <= r_addr + 1'b1;
                    r_state <= w_nextWordState;
                    if (w_lastWord) begin
                        r_burst <= 1'b0;
                    end
                end
                S_READ_MEM: begin
                    // Phase 0 issues the access, phase 1 picks up the data.
                    if (!r_memPhase) begin
                        r_memPhase <= 1'b1;
                    end else begin
                        r_memPhase <= 1'b0;
                        r_data     <= mem_dout;
                        r_byteCnt  <= '0;
                        r_state    <= S_ECHO;
                    end
                end
                S_ECHO: begin
                    // While TX is full nothing moves, so no byte is lost or repeated.
                    if (!tx_fifo_full) begin
                        r_data <= r_data << FIFO_WIDTH;
                        if (r_byteCnt == 2'(NB - 1)) begin
                            r_byteCnt <= '0;
                            r_count   <= r_count - 9'd1;
                            r_addr    <= r_addr + 1'b1;
                            r_state   <= w_nextWordState;
                            if (w_lastWord) begin
                                r_burst <= 1'b0;
                            end
                        end else begin
                            r_byteCnt <= r_byteCnt + 2'd1;
                        end
                    end
                end
                S_DISCARD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_fifo_rd_en = w_rdEn;
    assign tx_fifo_wr_en = (r_state == S_ECHO) && !tx_fifo_full;
    assign dout          = r_data[MEM_WIDTH-1 -: FIFO_WIDTH];
    assign mem_en        = (r_state == S_WRITE_MEM) ||
                           ((r_state == S_READ_MEM) && !r_memPhase);
    assign mem_we        = (r_state == S_WRITE_MEM) ? {NB{1'b1}} : {NB{1'b0}};
    assign mem_addr      = r_addr;
    assign mem_din       = r_data;
    assign state_leds    = {r_err, r_burst, r_state};

endmodule

// File: tb/tb_mem_burst_controller.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_controller
//
// Directed bench for mem_burst_controller (MEM_WIDTH=16, MEM_DEPTH=256).
// Surrounding models: an RX FIFO fed from a byte queue, a TX FIFO that
// records every pushed byte, and a 256x16 memory with one-cycle read data.
// ---------------------------------------------------------------------------
module tb_mem_burst_controller;

    logic        clk           = 1'b0;
    logic        rst_n         = 1'b1;
    logic        rx_fifo_empty = 1'b1;
    logic        rx_fifo_rd_en;
    logic [7:0]  din           = 8'h00;
    logic        tx_fifo_full  = 1'b0;
    logic        tx_fifo_wr_en;
    logic [7:0]  dout;
    logic        mem_en;
    logic [1:0]  mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout      = 16'h0000;
    logic [5:0]  state_leds;

    mem_burst_controller #(
        .FIFO_WIDTH(8),
        .MEM_WIDTH (16),
        .MEM_DEPTH (256)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_rd_en(rx_fifo_rd_en),
        .din          (din),
        .tx_fifo_full (tx_fifo_full),
        .tx_fifo_wr_en(tx_fifo_wr_en),
        .dout         (dout),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .state_leds   (state_leds)
    );

    always #5 clk = ~clk;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    int          txCyc[$];
    int          popCyc[$];
    logic [7:0]  wrAddrQ[$];
    logic        wrBurstQ[$];
    logic [7:0]  rdAddrQ[$];
    logic        rdBurstQ[$];
    logic [15:0] mem [0:255];
    logic [1:0]  lastWe       = 2'b00;
    int          cyc          = 0;
    int          weCycles     = 0;
    int          memEnCount   = 0;
    int          rdWhileEmpty = 0;
    int          wrWhileFull  = 0;

    int          checkCount   = 0;
    int          passCount    = 0;
    int          failCount    = 0;

    // Environment models: synchronous RX FIFO, TX sink and memory.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rx_fifo_rd_en) begin
            if (rx_fifo_empty || rxq.size() == 0) begin
                rdWhileEmpty = rdWhileEmpty + 1;
            end else begin
                din <= rxq.pop_front();
                popCyc.push_back(cyc);
            end
        end
        rx_fifo_empty <= (rxq.size() == 0);
        if (tx_fifo_wr_en) begin
            if (tx_fifo_full) begin
                wrWhileFull = wrWhileFull + 1;
            end
            txq.push_back(dout);
            txCyc.push_back(cyc);
        end
        if (mem_en) begin
            memEnCount = memEnCount + 1;
            mem_dout <= mem[mem_addr];
            if (mem_we != 2'b00) begin
                weCycles = weCycles + 1;
                lastWe   = mem_we;
                if (mem_we[1]) mem[mem_addr][15:8] = mem_din[15:8];
                if (mem_we[0]) mem[mem_addr][7:0]  = mem_din[7:0];
                wrAddrQ.push_back(mem_addr);
                wrBurstQ.push_back(state_leds[4]);
            end else begin
                rdAddrQ.push_back(mem_addr);
                rdBurstQ.push_back(state_leds[4]);
            end
        end else if (mem_we != 2'b00) begin
            weCycles = weCycles + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount = checkCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] seq, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rxq.push_back(seq[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic runUntilIdle(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 600 && !done; n++) begin
            @(negedge clk);
            if (rxq.size() == 0 && rx_fifo_empty && state_leds[3:0] == 4'd0) done = 1'b1;
        end
        checkOutput({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    int txBase, popBase, wrBase, rdBase, weBase, enBase, lat;
    bit reached;

    initial begin
        // Asynchronous reset, asserted before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_leds",   32'(state_leds),    32'h0);
        checkOutput("rst_rd_en",  32'(rx_fifo_rd_en), 32'h0);
        checkOutput("rst_wr_en",  32'(tx_fifo_wr_en), 32'h0);
        checkOutput("rst_mem_en", 32'(mem_en),        32'h0);
        checkOutput("rst_mem_we", 32'(mem_we),        32'h0);
        checkOutput("rst_addr",   32'(mem_addr),      32'h0);
        checkOutput("rst_dout",   32'(dout),          32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single write 0x10 <= 0xABCD, then single read back.
        weBase = weCycles; txBase = txq.size();
        applyStimulus(64'h31_10_AB_CD, 4);
        runUntilIdle("wr1");
        checkOutput("wr1_mem",    32'(mem[8'h10]),         32'hABCD);
        checkOutput("wr1_weCyc",  32'(weCycles - weBase),  32'd1);
        checkOutput("wr1_we",     32'(lastWe),             32'h3);
        checkOutput("wr1_noTx",   32'(txq.size() - txBase), 32'd0);
        txBase = txq.size(); popBase = popCyc.size();
        applyStimulus(64'h30_10, 2);
        runUntilIdle("rd1");
        checkOutput("rd1_txCnt",  32'(txq.size() - txBase), 32'd2);
        checkOutput("rd1_tx0",    32'(txq[txBase]),        32'hAB);
        checkOutput("rd1_tx1",    32'(txq[txBase+1]),      32'hCD);
        lat = txCyc[txCyc.size()-1] - popCyc[popBase];
        checkOutput("rd1_latency", 32'(lat <= 9), 32'd1);

        // Burst write of two words at 0xFE, 0xFF, then burst read back.
        wrBase = wrAddrQ.size();
        applyStimulus(64'h33_FE_01_11_22_33_44, 7);
        runUntilIdle("bw");
        checkOutput("bw_mem_fe",  32'(mem[8'hFE]),         32'h1122);
        checkOutput("bw_mem_ff",  32'(mem[8'hFF]),         32'h3344);
        checkOutput("bw_wrCnt",   32'(wrAddrQ.size() - wrBase), 32'd2);
        checkOutput("bw_addr1",   32'(wrAddrQ[wrBase+1]),  32'hFF);
        checkOutput("bw_burst0",  32'(wrBurstQ[wrBase]),   32'd1);
        checkOutput("bw_burst1",  32'(wrBurstQ[wrBase+1]), 32'd1);
        checkOutput("bw_burstEnd", 32'(state_leds[4]),     32'd0);
        txBase = txq.size(); rdBase = rdAddrQ.size();
        applyStimulus(64'h32_FE_01, 3);
        runUntilIdle("br");
        checkOutput("br_txCnt",   32'(txq.size() - txBase), 32'd4);
        checkOutput("br_tx",      {txq[txBase], txq[txBase+1], txq[txBase+2], txq[txBase+3]}, 32'h11223344);
        checkOutput("br_burst0",  32'(rdBurstQ[rdBase]),   32'd1);
        checkOutput("br_burst1",  32'(rdBurstQ[rdBase+1]), 32'd1);

        // Burst read wrapping from 0xFF to 0x00.
        applyStimulus(64'h31_00_01_02, 4);
        runUntilIdle("wr0");
        txBase = txq.size(); rdBase = rdAddrQ.size();
        applyStimulus(64'h32_FF_01, 3);
        runUntilIdle("wrap");
        checkOutput("wrap_addr0", 32'(rdAddrQ[rdBase]),    32'hFF);
        checkOutput("wrap_addr1", 32'(rdAddrQ[rdBase+1]),  32'h00);
        checkOutput("wrap_tx",    {txq[txBase], txq[txBase+1], txq[txBase+2], txq[txBase+3]}, 32'h33440102);

        // Illegal command: sticky error, no memory or TX activity.
        enBase = memEnCount; txBase = txq.size();
        applyStimulus(64'h55, 1);
        runUntilIdle("bad");
        checkOutput("bad_err",    32'(state_leds[5]),      32'd1);
        checkOutput("bad_memEn",  32'(memEnCount - enBase), 32'd0);
        checkOutput("bad_noTx",   32'(txq.size() - txBase), 32'd0);
        applyStimulus(64'h30_10, 2);
        runUntilIdle("bad_rd");
        checkOutput("bad_rd_tx",  {txq[txBase], txq[txBase+1]}, 32'hABCD);
        checkOutput("bad_sticky", 32'(state_leds[5]),      32'd1);

        // TX back-pressure held for 20 cycles during an echo.
        txBase = txq.size();
        @(negedge clk);
        tx_fifo_full = 1'b1;
        applyStimulus(64'h30_10, 2);
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            @(negedge clk);
            if (state_leds[3:0] == 4'd7) reached = 1'b1;
        end
        checkOutput("full_echo",  32'(reached), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("full_noTx",  32'(txq.size() - txBase), 32'd0);
        checkOutput("full_state", 32'(state_leds[3:0]),    32'd7);
        tx_fifo_full = 1'b0;
        runUntilIdle("full");
        checkOutput("full_txCnt", 32'(txq.size() - txBase), 32'd2);
        checkOutput("full_tx",    {txq[txBase], txq[txBase+1]}, 32'hABCD);
        checkOutput("full_wrWhileFull", 32'(wrWhileFull),  32'd0);

        // Reset in the middle of a burst write abandons the packet.
        popBase = popCyc.size();
        applyStimulus(64'h33_00_03_11, 4);
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            @(negedge clk);
            if (popCyc.size() - popBase >= 4) reached = 1'b1;
        end
        checkOutput("mid_popped", 32'(reached), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("mid_state",  32'(state_leds),         32'h34);
        weBase = weCycles;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_leds", 32'(state_leds),       32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        txBase = txq.size();
        applyStimulus(64'h30_00, 2);
        runUntilIdle("post");
        checkOutput("post_noWe",  32'(weCycles - weBase),  32'd0);
        checkOutput("post_tx",    {txq[txBase], txq[txBase+1]}, 32'h0102);
        checkOutput("post_leds",  32'(state_leds),         32'h0);
        checkOutput("rd_while_empty", 32'(rdWhileEmpty),   32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
